// File: rtl/core_pkg.sv
// Shared types and constants for the instruction-memory loader/server.
package core_pkg;

   // Loader FSM: LOAD fills memory from the byte stream, RUN serves the core.
   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } ldr_state_t;

   localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
   localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_ram.sv
// Word memory: 2**ADDR_W x 32, one synchronous write port, one asynchronous
// read port.
//   clk   : write clock
//   we    : write enable
//   waddr : write word address
//   wdata : write data
//   raddr : read word address
//   rdata : read data (combinational, returns pre-write contents on collision)
module imem_ram #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [31:0] mem [DEPTH];

   // Contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader_server.sv
// Instruction memory for the single-cycle core: loaded big-endian from a byte
// stream while the core is held in reset, then served combinationally by pc.
//   clk, rst   : clock, synchronous active-high reset
//   pc, instr  : core fetch address / instruction (zero latency)
//   core_rst   : held high until one cycle after RUN is entered
//   ld_start   : restart loading (honoured in RUN only)
//   ld_valid, ld_ready, ld_byte, ld_last : loader byte handshake
//   word_count : words written in the current image
//   ld_err     : sticky truncated-word / overflow flag for the current image
module imem_loader_server
   import core_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter bit          ZERO_FILL = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       pc,
   output logic [31:0]       instr,
   output logic              core_rst,
   input  logic              ld_start,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [7:0]        ld_byte,
   input  logic              ld_last,
   output logic [ADDR_W:0]   word_count,
   output logic              ld_err
);

   localparam int unsigned   DEPTH      = 1 << ADDR_W;
   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
   localparam logic [1:0]    LAST_IDX   = 2'(BYTES_PER_WORD - 1);

   ldr_state_t        state;
   logic [1:0]        byte_idx;
   logic [31:0]       asm_word;
   logic [31:0]       wr_word;
   logic              accept;
   logic              full;
   logic              word_done;
   logic              wr_en;
   logic [ADDR_W-1:0] rd_idx;
   logic [31:0]       rd_word;
   logic              pc_oob;
   logic              idx_unwritten;
   logic              unused_pc_lsb;

   // ld_ready is only high in LOAD, so acceptance implies LOAD.
   assign accept    = ld_valid && ld_ready;
   assign full      = (word_count == FULL_COUNT);
   assign word_done = (byte_idx == LAST_IDX) || ld_last;
   assign wr_en     = accept && !full && word_done;

   // Merge the incoming byte into its big-endian lane; lower lanes stay zero
   // because the assembly register is cleared after every word.
   always_comb begin
      wr_word = asm_word;
      case (byte_idx)
         2'd0:    wr_word[31:24] = ld_byte;
         2'd1:    wr_word[23:16] = ld_byte;
         2'd2:    wr_word[15:8]  = ld_byte;
         default: wr_word[7:0]   = ld_byte;
      endcase
   end

   // Loader FSM, byte assembler and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= LOAD;
         core_rst   <= 1'b1;
         ld_ready   <= 1'b1;
         word_count <= '0;
         ld_err     <= 1'b0;
         byte_idx   <= '0;
         asm_word   <= '0;
      end else begin
         core_rst <= (state != RUN);
         case (state)
            LOAD: begin
               if (accept) begin
                  if (full) begin
                     // Drop the byte, no wrap; keep ready so the source drains.
                     ld_err <= 1'b1;
                  end else if (word_done) begin
                     word_count <= word_count + (ADDR_W+1)'(1);
                     byte_idx   <= '0;
                     asm_word   <= '0;
                     if (byte_idx != LAST_IDX) ld_err <= 1'b1;
                  end else begin
                     byte_idx <= byte_idx + 2'd1;
                     asm_word <= wr_word;
                  end
                  if (ld_last) begin
                     state    <= RUN;
                     ld_ready <= 1'b0;
                     byte_idx <= '0;
                     asm_word <= '0;
                  end
               end
            end
            RUN: begin
               if (ld_start) begin
                  state      <= LOAD;
                  ld_ready   <= 1'b1;
                  word_count <= '0;
                  ld_err     <= 1'b0;
                  byte_idx   <= '0;
                  asm_word   <= '0;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   imem_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (word_count[ADDR_W-1:0]),
      .wdata (wr_word),
      .raddr (rd_idx),
      .rdata (rd_word)
   );

   // Zero-latency read path with out-of-range and unwritten-word masking.
   assign rd_idx        = pc[ADDR_W+1:2];
   assign pc_oob        = |pc[31:ADDR_W+2];
   assign idx_unwritten = ZERO_FILL && ({1'b0, rd_idx} >= word_count);
   assign instr         = (pc_oob || idx_unwritten) ? NOP_INSTR : rd_word;
   assign unused_pc_lsb = ^pc[1:0];

endmodule

// File: tb/tb_imem_loader_server.sv
// Bench for imem_loader_server: a 256-word and a 4-word instance share one
// stimulus stream and are checked every cycle against an image-level model.
module tb_imem_loader_server;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc = '0;
   logic        ld_start = 1'b0;
   logic        ld_valid = 1'b0;
   logic [7:0]  ld_byte = '0;
   logic        ld_last = 1'b0;

   logic [31:0] instr8, instr2;
   logic        crst8, crst2, rdy8, rdy2, err8, err2;
   logic [8:0]  wc8;
   logic [2:0]  wc2;

   int unsigned checks = 0;
   int unsigned errors = 0;
   bit          cmp_en = 1'b0;

   // Model: state of the loader plus the bytes accepted into the current image.
   bit          m_run  = 1'b0;
   bit          m_crst = 1'b1;
   bit          m_fin  = 1'b0;
   logic [7:0]  img[$];

   always #5 clk = ~clk;

   imem_loader_server #(.ADDR_W(8), .ZERO_FILL(1'b1)) u8 (
      .clk(clk), .rst(rst), .pc(pc), .instr(instr8), .core_rst(crst8),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(rdy8),
      .ld_byte(ld_byte), .ld_last(ld_last), .word_count(wc8), .ld_err(err8)
   );

   imem_loader_server #(.ADDR_W(2), .ZERO_FILL(1'b1)) u2 (
      .clk(clk), .rst(rst), .pc(pc), .instr(instr2), .core_rst(crst2),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(rdy2),
      .ld_byte(ld_byte), .ld_last(ld_last), .word_count(wc2), .ld_err(err2)
   );

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endfunction

   // Words in the image: completed words, plus a padded partial one once the
   // image has ended, limited to memory depth.
   function automatic int unsigned exp_wc(int unsigned depth);
      int unsigned n = img.size();
      int unsigned w = m_fin ? (n + 3) / 4 : n / 4;
      return (w > depth) ? depth : w;
   endfunction

   function automatic bit exp_err(int unsigned depth);
      int unsigned n = img.size();
      return (n > 4 * depth) || (m_fin && (n % 4 != 0));
   endfunction

   function automatic logic [31:0] exp_instr(int unsigned depth, logic [31:0] p);
      logic [31:0] idx = p >> 2;
      logic [31:0] w = '0;
      if (idx >= depth || idx >= exp_wc(depth)) return 32'h0;
      for (int b = 0; b < 4; b++) begin
         int unsigned k = idx * 4 + b;
         w = {w[23:0], (k < img.size()) ? img[k] : 8'h00};
      end
      return w;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_run = 1'b0; m_crst = 1'b1; m_fin = 1'b0; img.delete();
      end else begin
         m_crst = !m_run;
         if (!m_run) begin
            if (ld_valid) begin
               img.push_back(ld_byte);
               if (ld_last) begin m_run = 1'b1; m_fin = 1'b1; end
            end
         end else if (ld_start) begin
            m_run = 1'b0; m_fin = 1'b0; img.delete();
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("u8.word_count", 32'(wc8), 32'(exp_wc(256)));
         check("u8.ld_err",     32'(err8), 32'(exp_err(256)));
         check("u8.ld_ready",   32'(rdy8), 32'(!m_run));
         check("u8.core_rst",   32'(crst8), 32'(m_crst));
         check("u8.instr",      instr8, exp_instr(256, pc));
         check("u2.word_count", 32'(wc2), 32'(exp_wc(4)));
         check("u2.ld_err",     32'(err2), 32'(exp_err(4)));
         check("u2.ld_ready",   32'(rdy2), 32'(!m_run));
         check("u2.core_rst",   32'(crst2), 32'(m_crst));
         check("u2.instr",      instr2, exp_instr(4, pc));
      end
   end

   function automatic logic [31:0] rand_pc();
      case ($urandom_range(0, 7))
         0:       return 32'($urandom);
         1:       return 32'h0000_0400;
         default: return 32'(4 * $urandom_range(0, 10) + $urandom_range(0, 3));
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Idle cycles; when noisy and in RUN, junk on the loader port must be ignored.
   task automatic drive_idle(int n, bit noisy);
      for (int i = 0; i < n; i++) begin
         ld_valid = (noisy && m_run) ? 1'($urandom) : 1'b0;
         ld_last  = (noisy && m_run) ? 1'($urandom) : 1'b0;
         ld_byte  = 8'($urandom);
         pc       = rand_pc();
         step();
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic send_byte(logic [7:0] b, bit last, int gap);
      drive_idle(gap, 1'b0);
      ld_valid = 1'b1;
      ld_byte  = b;
      ld_last  = last;
      pc       = rand_pc();
      step();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic send_image(logic [7:0] bytes[$], bit gaps);
      for (int k = 0; k < bytes.size(); k++)
         send_byte(bytes[k], k == bytes.size() - 1, gaps ? (k % 2) : 0);
   endtask

   task automatic reload();
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
   endtask

   task automatic probe(logic [31:0] p, logic [31:0] e8, logic [31:0] e2, string name);
      pc = p;
      @(negedge clk);
      check({name, ".u8"}, instr8, e8);
      check({name, ".u2"}, instr2, e2);
   endtask

   initial begin
      logic [7:0] basic[$];
      logic [7:0] seq[$];

      basic = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};

      step();
      cmp_en = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("reset.word_count", 32'(wc8), 32'd0);
      check("reset.core_rst", 32'(crst8), 32'd1);
      check("reset.ld_ready", 32'(rdy8), 32'd1);

      // Basic load
      send_image(basic, 1'b0);
      @(negedge clk);
      check("basic.core_rst_held", 32'(crst8), 32'd1);
      check("basic.ready_low", 32'(rdy8), 32'd0);
      step();
      @(negedge clk);
      check("basic.core_rst_low", 32'(crst8), 32'd0);
      check("basic.word_count", 32'(wc8), 32'd2);
      check("basic.ld_err", 32'(err8), 32'd0);
      probe(32'h0, 32'h2008_0005, 32'h2008_0005, "basic.pc0");
      probe(32'h4, 32'h2009_000A, 32'h2009_000A, "basic.pc4");
      probe(32'h8, 32'h0, 32'h0, "basic.pc8");

      // Same image with gaps
      reload();
      send_image(basic, 1'b1);
      drive_idle(2, 1'b1);
      probe(32'h1, 32'h2008_0005, 32'h2008_0005, "gaps.pc1");
      probe(32'h7, 32'h2009_000A, 32'h2009_000A, "gaps.pc7");

      // Truncated final word
      reload();
      seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
      send_image(seq, 1'b0);
      @(negedge clk);
      check("trunc.word_count", 32'(wc8), 32'd2);
      check("trunc.ld_err", 32'(err8), 32'd1);
      probe(32'h4, 32'h1100_0000, 32'h1100_0000, "trunc.pc4");

      // Overflow of the 4-word instance
      reload();
      seq.delete();
      for (int k = 0; k < 20; k++) seq.push_back(8'(k + 1));
      send_image(seq, 1'b0);
      @(negedge clk);
      check("ovf.u2.word_count", 32'(wc2), 32'd4);
      check("ovf.u2.ld_err", 32'(err2), 32'd1);
      check("ovf.u8.word_count", 32'(wc8), 32'd5);
      check("ovf.u8.ld_err", 32'(err8), 32'd0);
      probe(32'h0, 32'h0102_0304, 32'h0102_0304, "ovf.pc0");
      probe(32'hC, 32'h0D0E_0F10, 32'h0D0E_0F10, "ovf.pc12");
      probe(32'h10, 32'h1112_1314, 32'h0, "ovf.pc16");

      // Reload: stale contents masked until rewritten
      reload();
      pc = 32'h0;
      @(negedge clk);
      check("reload.word_count", 32'(wc8), 32'd0);
      check("reload.instr_masked", instr8, 32'h0);
      step();
      @(negedge clk);
      check("reload.core_rst", 32'(crst8), 32'd1);
      seq = '{8'h00, 8'h00, 8'h00, 8'h20};
      send_image(seq, 1'b0);
      probe(32'h0, 32'h0000_0020, 32'h0000_0020, "reload.pc0");

      // Reset in the middle of a word
      reload();
      send_byte(8'hEE, 1'b0, 0);
      send_byte(8'hFF, 1'b0, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("midrst.word_count", 32'(wc8), 32'd0);
      check("midrst.ld_ready", 32'(rdy8), 32'd1);
      seq = '{8'h12, 8'h34, 8'h56, 8'h78};
      send_image(seq, 1'b0);
      probe(32'h0, 32'h1234_5678, 32'h1234_5678, "midrst.pc0");
      probe(32'h0000_0400, 32'h0, 32'h0, "midrst.pc_oob");

      // Random images with gaps, ignored ld_start, occasional resets
      for (int t = 0; t < 40; t++) begin
         int len = $urandom_range(1, 22);
         reload();
         for (int k = 0; k < len; k++) begin
            if (k == len / 2 && $urandom_range(0, 7) == 0) begin
               rst = 1'b1;
               step();
               rst = 1'b0;
            end
            ld_start = ($urandom_range(0, 9) == 0);
            send_byte(8'($urandom), k == len - 1, $urandom_range(0, 2));
            ld_start = 1'b0;
         end
         drive_idle($urandom_range(2, 8), 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_loader_server.md
Name: imem_loader_server

Overview:
- Instruction-side counterpart of the single-cycle mips core.
- The core drives pc and consumes instr; this block serves instr from an internal word memory.
- Before serving, it fills that memory from a byte-stream loader (UART/bench) and holds the core in reset via core_rst until loading completes.
- Sits beside the core at SoC top level.

Parameters:
- ADDR_W, 8, log2 of memory depth in 32-bit words (256 words).
- ZERO_FILL, 1, when 1, reads of never-loaded words return 32'h0000_0000 (nop).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- pc  input  32  byte address from core
- instr  output  32  instruction word for pc
- core_rst  output  1  reset to core; high while not in RUN
- ld_start  input  1  pulse: restart loading from address 0
- ld_valid  input  1  loader byte valid
- ld_ready  output  1  block accepts byte this cycle
- ld_byte  input  8  loader data byte
- ld_last  input  1  marks final byte of image, qualified by ld_valid&&ld_ready
- word_count  output  ADDR_W+1  words written in current image
- ld_err  output  1  sticky: truncated word or overflow in current image

Behaviour:
- One clock; reset is synchronous and active-high; ports clk, rst.
- Reset values: state=LOAD, core_rst=1, ld_ready=1, word_count=0, ld_err=0, byte index=0, assembly register=0. Memory contents are not reset.
- States:
  - LOAD: ld_ready=1, core_rst=1.
  - RUN: ld_ready=0, core_rst=0.
- core_rst is registered: it equals (state!=RUN) as of the previous edge. It deasserts the cycle after RUN is entered.
- Byte assembly is big-endian. Accepted bytes 0..3 of a word fill bits [31:24], [23:16], [15:8], [7:0].
- Word write: on the edge accepting byte 3, write the word at address word_count[ADDR_W-1:0], increment word_count, and reset the byte index to 0.
- Overflow: a byte accepted when word_count==2**ADDR_W is dropped (no write, no wrap) and ld_err is set. ld_ready stays 1 so the source drains.
- ld_last on byte 3: write the word, then LOAD->RUN on the same edge.
- ld_last on bytes 0..2: unfilled low bytes are zero, the partial word is written (if space), ld_err is set, and the state goes to RUN.
- Empty image is impossible: the transition requires an accepted ld_last byte.
- ld_start in RUN: next edge goes to LOAD, word_count=0, ld_err=0, byte index=0, core_rst=1 one cycle later. ld_start in LOAD is ignored.
- ld_valid in RUN is ignored; no acceptance while ld_ready=0.
- Read path is combinational, with zero latency as the single-cycle core requires:
  - index = pc[ADDR_W+1:2]; pc[1:0] is ignored.
  - instr = 0 if pc[31:ADDR_W+2]!=0.
  - instr = 0 if ZERO_FILL=1 and index>=word_count.
  - Otherwise instr = mem[index].
  - instr is also valid in LOAD; the core ignores it while in reset.
- Write and read of the same address in one cycle: the read returns the old contents. This only occurs in LOAD.
- Reset mid-load: partial word discarded, state LOAD, word_count=0. Memory keeps stale data, which is masked by ZERO_FILL.

Decomposition:
- Shared package core_pkg:
  - state enum ldr_state_t {LOAD, RUN}
  - NOP_INSTR = 32'h0
  - BYTES_PER_WORD = 4
- One natural sub-module, imem_ram: a 2**ADDR_W x 32 array with one synchronous write port and one asynchronous read port. It maps to distributed RAM.
- The FSM, byte assembler and read mask live in the top.

Test Plan:
- Basic load: after reset, send bytes 20,08,00,05, 20,09,00,0A with ld_last on byte 8. Expect word_count=2, ld_err=0, and core_rst falling 1 cycle after the last accept. Then pc=0 gives instr=32'h20080005; pc=4 gives 32'h2009000A; pc=8 gives 0.
- Backpressure/gaps: the same image with ld_valid toggled every other cycle produces identical memory. ld_ready=1 throughout LOAD and 0 in RUN.
- Truncated word: send 5 bytes AA,BB,CC,DD,11 with ld_last on the 5th. Expect word_count=2, mem[1]=32'h11000000, ld_err=1, state RUN.
- Overflow with ADDR_W=2: send 20 bytes with ld_last on the 20th. Expect word_count=4, ld_err=1, and mem[0..3] = the first 16 bytes with no wrap.
- Reload: in RUN, pulse ld_start. Expect core_rst=1 next cycle, word_count=0, and pc=0 gives instr=0 before new data arrives. Load 1 word 32'h00000020 and expect it served at pc=0.
- Reset mid-load: assert rst after 2 bytes of word 0. Expect LOAD, word_count=0, and the next 4 bytes form word 0 cleanly. Out-of-range pc=32'h0000_0400 with ADDR_W=8 returns 0.
